// File: rtl/pow_host.sv
`default_nettype none
// ============================================================================
//  Module      : pow_host
//  Description : Single-job host controller for an external x^e engine,
//                with watchdog abort and a result handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module pow_host #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic [31:0] in_e,
    input  logic [3:0]  in_tag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_y,
    output logic [3:0]  out_tag,
    output logic        out_timeout,
    output logic        eng_ld,
    output logic [31:0] eng_x,
    output logic [31:0] eng_e,
    input  logic        eng_done,
    input  logic [31:0] eng_y,
    output logic        eng_rst_n,
    output logic        busy,
    output logic [15:0] job_count
);

    localparam logic [15:0] c_TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_ABORT = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_timer;
    logic        r_abort_2nd;
    logic        r_rst_d;
    logic [31:0] r_x;
    logic [31:0] r_e;
    logic [31:0] r_y;
    logic [3:0]  r_tag;
    logic        r_timeout;
    logic [15:0] r_job_count;

    logic w_accept;
    logic w_done;
    logic w_expire;
    logic w_deliver;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_done    = (r_state == S_WAIT) && eng_done;
    // eng_done takes priority over the watchdog in the same cycle
    assign w_expire  = (r_state == S_WAIT) && !eng_done && (r_timer == c_TIMER_LAST);
    assign w_deliver = (r_state == S_OUT) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        eng_ld      = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                eng_ld      = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_done) begin
                    w_state_nxt = S_OUT;
                end else if (w_expire) begin
                    w_state_nxt = S_ABORT;
                end
            end
            S_ABORT: begin
                if (r_abort_2nd) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Engine reset is held one extra cycle past rst so the engine leaves
    // reset only after the host is settled in IDLE.
    always_ff @(posedge clk) begin
        r_rst_d <= rst;
    end

    assign eng_rst_n = !rst && !r_rst_d && (r_state != S_ABORT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer     <= 16'd0;
            r_abort_2nd <= 1'b0;
            r_x         <= 32'd0;
            r_e         <= 32'd0;
            r_y         <= 32'd0;
            r_tag       <= 4'd0;
            r_timeout   <= 1'b0;
            r_job_count <= 16'd0;
        end else begin
            if (w_accept) begin
                r_x   <= in_x;
                r_e   <= in_e;
                r_tag <= in_tag;
            end

            if (r_state == S_LOAD) begin
                r_timer <= 16'd0;
            end else if (r_state == S_WAIT) begin
                r_timer <= r_timer + 16'd1;
            end

            r_abort_2nd <= (r_state == S_ABORT) && !r_abort_2nd;

            if (w_done) begin
                r_y       <= eng_y;
                r_timeout <= 1'b0;
            end else if (w_expire) begin
                r_y       <= 32'd0;
                r_timeout <= 1'b1;
            end

            if (w_deliver && !r_timeout) begin
                r_job_count <= r_job_count + 16'd1;
            end
        end
    end

    assign eng_x       = r_x;
    assign eng_e       = r_e;
    assign out_y       = r_y;
    assign out_tag     = r_tag;
    assign out_timeout = r_timeout;
    assign job_count   = r_job_count;

endmodule
`default_nettype wire

// File: tb/tb_pow_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pow_host
//  Description : Randomised scoreboard bench for pow_host with a
//                behavioural engine whose latency is chosen per job.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pow_host;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [31:0] in_e;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic [3:0]  out_tag;
    logic        out_timeout;
    logic        eng_ld;
    logic [31:0] eng_x;
    logic [31:0] eng_e;
    logic        eng_done = 1'b0;
    logic [31:0] eng_y = 32'd0;
    logic        eng_rst_n;
    logic        busy;
    logic [15:0] job_count;

    pow_host #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_e        (in_e),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_y       (out_y),
        .out_tag     (out_tag),
        .out_timeout (out_timeout),
        .eng_ld      (eng_ld),
        .eng_x       (eng_x),
        .eng_e       (eng_e),
        .eng_done    (eng_done),
        .eng_y       (eng_y),
        .eng_rst_n   (eng_rst_n),
        .busy        (busy),
        .job_count   (job_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] y;
        logic [3:0]  tag;
        logic        to;
        int          lat;
    } job_t;

    job_t        exp_q[$];
    int          lat_q[$];
    logic [31:0] got_y[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic        mon_en   = 1'b0;
    logic        hold     = 1'b0;
    int          cur_lat  = 1;
    int          n_out    = 0;
    logic [31:0] last_y;
    logic [3:0]  last_tag;
    logic        last_to;

    logic        eng_busy  = 1'b0;
    logic        real_done = 1'b0;
    int          eng_cnt   = 0;
    logic [31:0] ex        = 32'd0;
    logic [31:0] ee        = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Engine arithmetic: square-and-multiply, wrapping at 32 bits
    function automatic logic [31:0] eng_pow(input logic [31:0] x, input logic [31:0] e);
        logic [31:0] r = 32'd1;
        logic [31:0] b = x;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = r * b;
            b = b * b;
        end
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    // Behavioural engine: done arrives `lat` cycles after the ld cycle; lat<0 never finishes
    initial forever begin : engine
        int lat;
        @(posedge clk);
        eng_done  <= 1'b0;
        real_done <= 1'b0;
        if (!eng_rst_n) begin
            eng_busy <= 1'b0;
        end else if (eng_busy) begin
            if (eng_cnt <= 1) begin
                eng_busy  <= 1'b0;
                eng_done  <= 1'b1;
                real_done <= 1'b1;
                eng_y     <= eng_pow(ex, ee);
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end else if (eng_ld) begin
            lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
            ex <= eng_x;
            ee <= eng_e;
            if (lat == 1) begin
                eng_done  <= 1'b1;
                real_done <= 1'b1;
                eng_y     <= eng_pow(eng_x, eng_e);
            end else begin
                eng_busy <= 1'b1;
                eng_cnt  <= (lat < 0) ? 1000000 : lat - 1;
            end
        end else if (mon_en && $urandom_range(0, 9) == 0) begin
            eng_done <= 1'b1;
            eng_y    <= $urandom;
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard
    initial forever begin : monitor
        int          ld_cyc;
        int          acc_cyc;
        int          exp_first;
        int          last_done_cyc;
        int          low_run;
        logic        prev_ld, prev_ov, prev_or, prev_to;
        logic [31:0] prev_y;
        logic [3:0]  prev_tag;
        logic [15:0] exp_count;
        job_t        j;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            lat_q.delete();
            exp_count     = 16'd0;
            last_done_cyc = -100;
            acc_cyc       = -100;
            exp_first     = 0;
        end
        if (!mon_en) begin
            prev_ld = 1'b0;
            prev_ov = 1'b0;
            prev_or = 1'b0;
            low_run = 0;
        end else begin
            chk("job_count", {16'd0, job_count}, {16'd0, exp_count});
            if (eng_done && real_done) last_done_cyc = cyc;
            if (eng_busy) begin
                chk("eng_x_stable", eng_x, ex);
                chk("eng_e_stable", eng_e, ee);
            end
            if (eng_ld) begin
                chk("eng_ld_single", {31'd0, prev_ld}, 32'd0);
                chk("ld_after_accept", cyc, acc_cyc + 1);
                chk("ld_gap_after_done", {31'd0, (cyc - last_done_cyc >= 2)}, 32'd1);
                ld_cyc = cyc;
                if (exp_q.size() > 0)
                    exp_first = exp_q[0].to ? ld_cyc + TO + 3 : ld_cyc + exp_q[0].lat + 1;
            end
            if (!eng_rst_n) begin
                low_run++;
            end else if (low_run != 0) begin
                chk("eng_rst_n_low_cycles", low_run, 2);
                low_run = 0;
            end
            if (out_valid) begin
                chk("in_ready_while_out", {31'd0, in_ready}, 32'd0);
                if (!prev_ov) begin
                    chk("out_latency", cyc, exp_first);
                end else if (!prev_or) begin
                    chk("hold_y", out_y, prev_y);
                    chk("hold_tag", {28'd0, out_tag}, {28'd0, prev_tag});
                    chk("hold_timeout", {31'd0, out_timeout}, {31'd0, prev_to});
                end
                if (out_ready) begin
                    last_y   = out_y;
                    last_tag = out_tag;
                    last_to  = out_timeout;
                    got_y.push_back(out_y);
                    n_out++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        j = exp_q.pop_front();
                        chk("out_y", out_y, j.y);
                        chk("out_tag", {28'd0, out_tag}, {28'd0, j.tag});
                        chk("out_timeout", {31'd0, out_timeout}, {31'd0, j.to});
                        if (!j.to) exp_count = exp_count + 16'd1;
                    end
                end
            end
            if (in_valid && in_ready) begin
                j.tag = in_tag;
                j.lat = cur_lat;
                j.to  = (cur_lat < 0) || (cur_lat > TO);
                j.y   = j.to ? 32'd0 : (in_x ** in_e);
                exp_q.push_back(j);
                lat_q.push_back(cur_lat);
                acc_cyc = cyc;
            end
            prev_ld  = eng_ld;
            prev_ov  = out_valid;
            prev_or  = out_ready;
            prev_y   = out_y;
            prev_tag = out_tag;
            prev_to  = out_timeout;
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] e, input logic [3:0] tag, input int lat);
        int n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_x     = x;
        in_e     = e;
        in_tag   = tag;
        cur_lat  = lat;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 3000) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin : stim
        logic [15:0] c0;
        int          n;
        int          r;
        int          outs0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_x     = 32'd0;
        in_e     = 32'd0;
        in_tag   = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_eng_ld", {31'd0, eng_ld}, 32'd0);
        chk("rst_job_count", {16'd0, job_count}, 32'd0);
        chk("rst_out_y", out_y, 32'd0);
        chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
        chk("rst_out_timeout", {31'd0, out_timeout}, 32'd0);
        chk("rst_eng_x", eng_x, 32'd0);
        chk("rst_eng_e", eng_e, 32'd0);
        chk("rst_eng_rst_n", {31'd0, eng_rst_n}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("eng_rst_n_first_cycle", {31'd0, eng_rst_n}, 32'd0);
        @(negedge clk);
        chk("eng_rst_n_released", {31'd0, eng_rst_n}, 32'd1);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        send(32'd3, 32'd5, 4'h1, 4);
        drain();
        chk("x3e5_y", last_y, 32'd243);
        chk("x3e5_timeout", {31'd0, last_to}, 32'd0);
        chk("x3e5_count", {16'd0, job_count}, 32'd1);

        got_y.delete();
        send(32'd2, 32'd31, 4'h2, 3);
        send(32'd2, 32'd32, 4'h3, 5);
        drain();
        chk("b2b_count", got_y.size(), 32'd2);
        if (got_y.size() == 2) begin
            chk("b2b_first_y", got_y[0], 32'h8000_0000);
            chk("b2b_second_y", got_y[1], 32'h0000_0000);
        end

        send(32'd7, 32'd0, 4'hA, 2);
        drain();
        chk("e0_y", last_y, 32'd1);
        chk("e0_tag", {28'd0, last_tag}, 32'hA);

        c0 = job_count;
        send(32'd5, 32'd5, 4'h4, -1);
        drain();
        chk("hang_timeout", {31'd0, last_to}, 32'd1);
        chk("hang_y", last_y, 32'd0);
        chk("hang_count_same", {16'd0, job_count}, {16'd0, c0});

        send(32'd3, 32'd3, 4'h5, TO);
        drain();
        chk("done_at_timeout_wins", {31'd0, last_to}, 32'd0);
        chk("done_at_timeout_y", last_y, 32'd27);
        send(32'd3, 32'd3, 4'h6, TO + 1);
        drain();
        chk("done_after_timeout", {31'd0, last_to}, 32'd1);

        hold = 1'b1;
        outs0 = n_out;
        send(32'd11, 32'd3, 4'h9, 3);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (10) begin
            chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        hold = 1'b0;
        drain();
        chk("stall_single_result", n_out - outs0, 32'd1);
        chk("stall_y", last_y, 32'd1331);
        chk("stall_tag", {28'd0, last_tag}, 32'h9);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 19);
            send($urandom,
                 ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40),
                 4'($urandom),
                 (r == 0) ? -1 : $urandom_range(1, 12));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        drain();

        outs0 = n_out;
        send(32'd9, 32'd9, 4'hB, -1);
        repeat (20) @(posedge clk);
        #1;
        rst    = 1'b1;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_eng_rst_n", {31'd0, eng_rst_n}, 32'd0);
        chk("midrst_job_count", {16'd0, job_count}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (40) @(negedge clk);
        chk("midrst_no_result", n_out - outs0, 32'd0);

        send(32'd3, 32'd5, 4'h7, 3);
        drain();
        chk("post_rst_y", last_y, 32'd243);
        chk("post_rst_count", {16'd0, job_count}, 32'd1);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
